// File: rtl/ppi_bus_ctrl_if.sv
// Host-side bus of the PPI bus control stage.
// Strobe protocol: the host asserts cs_n and exactly one of rd_n / wr_n
// (all active-low, asynchronous to clk). a and d_in must be stable while
// the strobe is low. d_out is meaningful only while d_oe is high.
interface ppi_bus_ctrl_if;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic [1:0] a;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe;

   modport master (
      output cs_n, rd_n, wr_n, a, d_in,
      input  d_out, d_oe
   );

   modport slave (
      input  cs_n, rd_n, wr_n, a, d_in,
      output d_out, d_oe
   );
endinterface

// File: rtl/ppi_bus_ctrl.sv
// ppi_bus_ctrl: PPI host bus interface and read/write control.
// Synchronises the host strobes, decodes A1:A0, issues one-cycle write
// pulses to port A / port B / control word register and owns the port C
// latch (including bit set/reset updates).
// Optional feature macro: PPI_BUS_RDBACK_EN -- when defined, a read of
// address 11 returns the current control word instead of 8'hFF.
module ppi_bus_ctrl (
   input  logic                 clk,
   input  logic                 rst_n,
   ppi_bus_ctrl_if.slave        host,
   input  logic [7:0]           pa_in,
   input  logic [7:0]           pb_in,
   input  logic [7:0]           pc_in,
   output logic                 pa_wr,
   output logic                 pb_wr,
   output logic [7:0]           port_wdata,
   output logic                 cw_en,
   output logic [7:0]           cw_data,
   output logic [7:0]           pc_latch,
   output logic [1:0]           state_dbg
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_RD   = 2'd3;

   localparam logic [7:0] CW_DEFAULT = 8'h9B;

   // {cs_n, rd_n, wr_n} synchroniser stages
   logic [2:0] sync1_q, sync2_q;
   logic       s_cs_n, s_rd_n, s_wr_n;

   logic [1:0] state_q, state_d;
   logic [1:0] a_q, a_d;
   logic [7:0] dat_q, dat_d;
   logic       pa_wr_q, pa_wr_d;
   logic       pb_wr_q, pb_wr_d;
   logic       cw_en_q, cw_en_d;
   logic [7:0] port_wdata_q, port_wdata_d;
   logic [7:0] cw_data_q, cw_data_d;
   logic [7:0] pc_latch_q, pc_latch_d;
   logic       d_oe_q, d_oe_d;
   logic [7:0] d_out_q, d_out_d;
   logic [7:0] rd_data;

   assign s_cs_n = sync2_q[2];
   assign s_rd_n = sync2_q[1];
   assign s_wr_n = sync2_q[0];

   // Two-flop synchroniser; strobes idle high so reset to all ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
      end else begin
         sync1_q <= {host.cs_n, host.rd_n, host.wr_n};
         sync2_q <= sync1_q;
      end
   end

   // Read source select; the live address is used so d_out is valid on RD entry
   always_comb begin
      rd_data = 8'h00;
      case (host.a)
         2'b00:   rd_data = pa_in;
         2'b01:   rd_data = pb_in;
         2'b10:   rd_data = pc_in;
`ifdef PPI_BUS_RDBACK_EN
         default: rd_data = cw_data_q;
`else
         default: rd_data = 8'hFF;
`endif
      endcase
   end

   // FSM next state, write commit decode and read data path
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      dat_d        = dat_q;
      pa_wr_d      = 1'b0;
      pb_wr_d      = 1'b0;
      cw_en_d      = 1'b0;
      port_wdata_d = port_wdata_q;
      cw_data_d    = cw_data_q;
      pc_latch_d   = pc_latch_q;
      d_oe_d       = 1'b0;
      d_out_d      = d_out_q;

      case (state_q)
         ST_INIT: begin
            // Load the default control word once after reset
            cw_en_d   = 1'b1;
            cw_data_d = CW_DEFAULT;
            state_d   = ST_IDLE;
         end
         ST_IDLE: begin
            // Both strobes low together is illegal and ignored
            if (!s_cs_n && !s_wr_n && s_rd_n) begin
               state_d = ST_WR;
            end else if (!s_cs_n && !s_rd_n && s_wr_n) begin
               state_d = ST_RD;
               d_oe_d  = 1'b1;
               d_out_d = rd_data;
            end
         end
         ST_WR: begin
            if (s_wr_n) begin
               // Strobe released: commit the last captured a/d_in.
               // cs_n deliberately does not gate the commit.
               state_d = ST_IDLE;
               case (a_q)
                  2'b00: begin
                     pa_wr_d      = 1'b1;
                     port_wdata_d = dat_q;
                  end
                  2'b01: begin
                     pb_wr_d      = 1'b1;
                     port_wdata_d = dat_q;
                  end
                  2'b10: begin
                     pc_latch_d = dat_q;
                  end
                  default: begin
                     cw_en_d   = 1'b1;
                     cw_data_d = dat_q;
                     if (dat_q[7]) begin
                        pc_latch_d = 8'h00;
                     end else begin
                        pc_latch_d[dat_q[3:1]] = dat_q[0];
                     end
                  end
               endcase
            end else begin
               a_d   = host.a;
               dat_d = host.d_in;
            end
         end
         default: begin
            // ST_RD: wr_n is ignored here until the read ends
            a_d   = host.a;
            dat_d = host.d_in;
            if (s_rd_n || s_cs_n) begin
               state_d = ST_IDLE;
            end else begin
               d_oe_d  = 1'b1;
               d_out_d = rd_data;
            end
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         a_q          <= 2'b00;
         dat_q        <= 8'h00;
         pa_wr_q      <= 1'b0;
         pb_wr_q      <= 1'b0;
         cw_en_q      <= 1'b0;
         port_wdata_q <= 8'h00;
         cw_data_q    <= CW_DEFAULT;
         pc_latch_q   <= 8'h00;
         d_oe_q       <= 1'b0;
         d_out_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         dat_q        <= dat_d;
         pa_wr_q      <= pa_wr_d;
         pb_wr_q      <= pb_wr_d;
         cw_en_q      <= cw_en_d;
         port_wdata_q <= port_wdata_d;
         cw_data_q    <= cw_data_d;
         pc_latch_q   <= pc_latch_d;
         d_oe_q       <= d_oe_d;
         d_out_q      <= d_out_d;
      end
   end

   assign host.d_out = d_out_q;
   assign host.d_oe  = d_oe_q;
   assign pa_wr      = pa_wr_q;
   assign pb_wr      = pb_wr_q;
   assign port_wdata = port_wdata_q;
   assign cw_en      = cw_en_q;
   assign cw_data    = cw_data_q;
   assign pc_latch   = pc_latch_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Testbench for ppi_bus_ctrl: table of host writes with expected pulses and
// latch contents, plus directed sequences for reads, illegal strobes and
// reset during a write.
module tb_ppi_bus_ctrl;

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
`ifdef PPI_BUS_RDBACK_EN
   localparam logic [7:0] RD11 = 8'h9B;
`else
   localparam logic [7:0] RD11 = 8'hFF;
`endif

   // pulse kinds in the write table
   localparam int K_PA   = 0;
   localparam int K_PB   = 1;
   localparam int K_NONE = 2;
   localparam int K_CW   = 3;

   typedef struct {
      logic [1:0] a;
      logic [7:0] d;
      int         kind;
      logic [7:0] exp_pc;
      logic [7:0] exp_cw;
   } wr_vec_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] pa_in, pb_in, pc_in;
   logic       pa_wr, pb_wr, cw_en;
   logic [7:0] port_wdata, cw_data, pc_latch;
   logic [1:0] state_dbg;

   int checks;
   int errors;

   // results gathered by the write monitor
   int         pa_n, pb_n, cw_n, pulse_k;
   logic [7:0] seen_wdata, seen_cw;

   ppi_bus_ctrl_if host ();

   ppi_bus_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host       (host.slave),
      .pa_in      (pa_in),
      .pb_in      (pb_in),
      .pc_in      (pc_in),
      .pa_wr      (pa_wr),
      .pb_wr      (pb_wr),
      .port_wdata (port_wdata),
      .cw_en      (cw_en),
      .cw_data    (cw_data),
      .pc_latch   (pc_latch),
      .state_dbg  (state_dbg)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Watch n cycles for pulses; k counts negedges after the stimulus change
   task automatic watch_pulses(input int n);
      pa_n = 0; pb_n = 0; cw_n = 0; pulse_k = -1;
      seen_wdata = 8'h00; seen_cw = 8'h00;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (pa_wr) begin pa_n++; pulse_k = k; seen_wdata = port_wdata; end
         if (pb_wr) begin pb_n++; pulse_k = k; seen_wdata = port_wdata; end
         if (cw_en) begin cw_n++; pulse_k = k; seen_cw = cw_data; end
      end
   endtask

   // Host write; cs_n rises with wr_n, which must not block the commit
   task automatic do_write(input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      host.a    = addr;
      host.d_in = data;
      host.cs_n = 1'b0;
      @(negedge clk);
      host.wr_n = 1'b0;
      repeat (4) @(negedge clk);
      host.wr_n = 1'b1;
      host.cs_n = 1'b1;
      watch_pulses(6);
   endtask

   // Host read; all pins change to nv after the first valid cycle
   task automatic do_read(input string tag, input logic [1:0] addr, input logic [7:0] nv,
                          input logic [7:0] exp1, input logic [7:0] exp2);
      @(negedge clk);
      host.a    = addr;
      host.cs_n = 1'b0;
      @(negedge clk);
      host.rd_n = 1'b0;
      @(negedge clk); chk({tag, "_oe_k1"}, d_oe_w(), 0);
      @(negedge clk); chk({tag, "_oe_k2"}, d_oe_w(), 0);
      @(negedge clk); chk({tag, "_oe_k3"}, d_oe_w(), 1);
      chk({tag, "_dout1"}, host.d_out, exp1);
      pa_in = nv; pb_in = nv; pc_in = nv;
      @(negedge clk); chk({tag, "_dout2"}, host.d_out, exp2);
      host.rd_n = 1'b1;
      @(negedge clk); chk({tag, "_oe_r1"}, d_oe_w(), 1);
      @(negedge clk); chk({tag, "_oe_r2"}, d_oe_w(), 1);
      @(negedge clk); chk({tag, "_oe_r3"}, d_oe_w(), 0);
      host.cs_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   function automatic logic d_oe_w();
      return host.d_oe;
   endfunction

   wr_vec_t vecs[9];

   initial begin
      checks = 0;
      errors = 0;
      host.cs_n = 1'b1; host.rd_n = 1'b1; host.wr_n = 1'b1;
      host.a = 2'b00; host.d_in = 8'h00;
      pa_in = 8'h11; pb_in = 8'h22; pc_in = 8'h3C;

      vecs[0] = '{2'b00, 8'h5A, K_PA,   8'h00, 8'h9B};
      vecs[1] = '{2'b01, 8'hC3, K_PB,   8'h00, 8'h9B};
      vecs[2] = '{2'b11, 8'h80, K_CW,   8'h00, 8'h80};
      vecs[3] = '{2'b11, 8'h07, K_CW,   8'h08, 8'h07};
      vecs[4] = '{2'b11, 8'h06, K_CW,   8'h00, 8'h06};
      vecs[5] = '{2'b10, 8'hF0, K_NONE, 8'hF0, 8'h06};
      vecs[6] = '{2'b11, 8'h0E, K_CW,   8'h70, 8'h0E};
      vecs[7] = '{2'b11, 8'h03, K_CW,   8'h72, 8'h03};
      vecs[8] = '{2'b11, 8'h85, K_CW,   8'h00, 8'h85};

      // reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", state_dbg, ST_INIT);
      chk("rst_cw_data", cw_data, 8'h9B);
      chk("rst_pulses", {pa_wr, pb_wr, cw_en}, 3'b000);
      chk("rst_pc_latch", pc_latch, 8'h00);
      chk("rst_wdata", port_wdata, 8'h00);
      chk("rst_oe_dout", {host.d_oe, host.d_out}, 9'h000);

      // INIT pulse after release
      rst_n = 1'b1;
      watch_pulses(5);
      chk("init_cw_cnt", cw_n, 1);
      chk("init_cw_k", pulse_k, 1);
      chk("init_cw_data", seen_cw, 8'h9B);
      chk("init_port_pulses", pa_n + pb_n, 0);
      chk("init_state", state_dbg, ST_IDLE);

      // control readback while cw_data is still the default
      do_read("rd11", 2'b11, 8'h44, RD11, RD11);
      pa_in = 8'h11; pb_in = 8'h22; pc_in = 8'h3C;
      do_read("rd00", 2'b00, 8'h66, 8'h11, 8'h66);
      pa_in = 8'h11; pb_in = 8'h22; pc_in = 8'h3C;

      // table of writes
      for (int i = 0; i < 9; i++) begin
         do_write(vecs[i].a, vecs[i].d);
         chk($sformatf("w%0d_pa_cnt", i), pa_n, (vecs[i].kind == K_PA) ? 1 : 0);
         chk($sformatf("w%0d_pb_cnt", i), pb_n, (vecs[i].kind == K_PB) ? 1 : 0);
         chk($sformatf("w%0d_cw_cnt", i), cw_n, (vecs[i].kind == K_CW) ? 1 : 0);
         chk($sformatf("w%0d_pulse_k", i), pulse_k, (vecs[i].kind == K_NONE) ? -1 : 3);
         if (vecs[i].kind == K_PA || vecs[i].kind == K_PB)
            chk($sformatf("w%0d_wdata", i), seen_wdata, vecs[i].d);
         if (vecs[i].kind == K_CW)
            chk($sformatf("w%0d_cw_pulse_data", i), seen_cw, vecs[i].d);
         chk($sformatf("w%0d_pc_latch", i), pc_latch, vecs[i].exp_pc);
         chk($sformatf("w%0d_cw_data", i), cw_data, vecs[i].exp_cw);
      end

      // read of port C pins (latch holds 00 now, pins drive 3C then 5A)
      do_read("rd10", 2'b10, 8'h5A, 8'h3C, 8'h5A);
      pa_in = 8'h11; pb_in = 8'h22; pc_in = 8'h3C;

      // illegal: rd_n and wr_n low together
      @(negedge clk);
      host.a = 2'b00; host.d_in = 8'hEE;
      host.cs_n = 1'b0; host.rd_n = 1'b0; host.wr_n = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("ill_oe_k%0d", k), host.d_oe, 1'b0);
         chk($sformatf("ill_state_k%0d", k), state_dbg, ST_IDLE);
      end
      host.cs_n = 1'b1; host.rd_n = 1'b1; host.wr_n = 1'b1;
      watch_pulses(6);
      chk("ill_pulses", pa_n + pb_n + cw_n, 0);
      chk("ill_pc_latch", pc_latch, 8'h00);

      // reset during a write to port A
      @(negedge clk);
      host.a = 2'b00; host.d_in = 8'hA5; host.cs_n = 1'b0;
      @(negedge clk);
      host.wr_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_state_wr", state_dbg, 2'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_state", state_dbg, ST_INIT);
      chk("mid_rst_cw_data", cw_data, 8'h9B);
      chk("mid_rst_wdata", port_wdata, 8'h00);
      @(negedge clk);
      host.wr_n = 1'b1; host.cs_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      watch_pulses(6);
      chk("mid_pa_cnt", pa_n, 0);
      chk("mid_cw_cnt", cw_n, 1);
      chk("mid_cw_k", pulse_k, 1);
      chk("mid_cw_data", seen_cw, 8'h9B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // watchdog: the sequence is fixed-length, this only guards against stalls
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
